// File: rtl/user_mgr_arbiter.sv
// -----------------------------------------------------------------------------
// user_mgr_arbiter
//
// Shares one OBI manager port between NumMgr requesters. The A channel and the
// grant path are purely combinational, so a request reaches out_req_o in the
// same cycle. An in-order index FIFO remembers who was granted so that each
// response is steered back to its originator, also with zero latency.
//
// Configuration macro:
//   USER_MGR_ARB_RR_EN  defined     -> round-robin arbitration (prio_reg exists)
//                       not defined -> fixed priority, lowest index wins
//
// Parameters:
//   NumMgr    number of requesters (>= 2)
//   MaxTrans  max granted-but-unanswered transactions, also the FIFO depth (>= 1)
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   mgr_req_i / mgr_gnt_o         per-requester request / grant
//   mgr_addr_i, mgr_we_i,
//   mgr_be_i, mgr_wdata_i         per-requester A-channel payload
//   mgr_rvalid_o                  per-requester response valid
//   mgr_rdata_o, mgr_err_o        response data / error, broadcast
//   out_req_o, out_addr_o, out_we_o,
//   out_be_o, out_wdata_o         shared A channel toward the crossbar
//   out_gnt_i                     shared grant
//   out_rvalid_i, out_rdata_i,
//   out_err_i                     shared R channel
// -----------------------------------------------------------------------------
module user_mgr_arbiter #(
    parameter int unsigned NumMgr   = 2,
    parameter int unsigned MaxTrans = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumMgr-1:0]        mgr_req_i,
    output logic [NumMgr-1:0]        mgr_gnt_o,
    input  logic [NumMgr-1:0][31:0]  mgr_addr_i,
    input  logic [NumMgr-1:0]        mgr_we_i,
    input  logic [NumMgr-1:0][3:0]   mgr_be_i,
    input  logic [NumMgr-1:0][31:0]  mgr_wdata_i,
    output logic [NumMgr-1:0]        mgr_rvalid_o,
    output logic [31:0]              mgr_rdata_o,
    output logic                     mgr_err_o,
    output logic                     out_req_o,
    output logic [31:0]              out_addr_o,
    output logic                     out_we_o,
    output logic [3:0]               out_be_o,
    output logic [31:0]              out_wdata_o,
    input  logic                     out_gnt_i,
    input  logic                     out_rvalid_i,
    input  logic [31:0]              out_rdata_i,
    input  logic                     out_err_i
);

    localparam int unsigned IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

    typedef logic [IdxW-1:0] idx_t;

    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxTrans);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxTrans - 1);

    logic            locked_reg, locked_next;
    idx_t            lock_idx_reg, lock_idx_next;
    logic [CntW-1:0] cnt_reg, cnt_next;
    logic [PtrW-1:0] wr_ptr_reg, rd_ptr_reg;

    idx_t winner;
    idx_t head_idx;
    idx_t fifo_view [MaxTrans];
    logic issue_en;
    logic handshake;
    logic fifo_empty;
    logic pop;

    // -------------------------------------------------------------------------
    // Winner selection. A pending lock overrides the search so that the
    // request that is waiting for gnt keeps req/addr stable.
    // -------------------------------------------------------------------------
`ifdef USER_MGR_ARB_RR_EN
    idx_t        prio_reg;
    idx_t        cand;
    logic        found;
    int unsigned cand_sum;

    always_comb begin
        winner   = '0;
        cand     = '0;
        found    = 1'b0;
        cand_sum = 0;
        // Search upward from the pointer, wrapping at NumMgr.
        for (int unsigned k = 0; k < NumMgr; k++) begin
            cand_sum = (32'(prio_reg) + k) % NumMgr;
            cand     = idx_t'(cand_sum);
            if (!found && mgr_req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
        if (locked_reg) begin
            winner = lock_idx_reg;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_reg <= '0;
        end else if (handshake) begin
            prio_reg <= (32'(winner) == NumMgr - 1) ? '0 : winner + idx_t'(1);
        end
    end
`else
    always_comb begin
        winner = '0;
        // Descending scan so the lowest asserted index is the last one written.
        for (int k = NumMgr - 1; k >= 0; k--) begin
            if (mgr_req_i[idx_t'(k)]) begin
                winner = idx_t'(k);
            end
        end
        if (locked_reg) begin
            winner = lock_idx_reg;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // A channel and grant
    // -------------------------------------------------------------------------
    assign issue_en    = (cnt_reg < MaxCnt);
    assign out_req_o   = issue_en & mgr_req_i[winner];
    assign out_addr_o  = mgr_addr_i[winner];
    assign out_we_o    = mgr_we_i[winner];
    assign out_be_o    = mgr_be_i[winner];
    assign out_wdata_o = mgr_wdata_i[winner];
    assign handshake   = out_req_o & out_gnt_i;

    always_comb begin
        mgr_gnt_o = '0;
        if (issue_en) begin
            mgr_gnt_o[winner] = out_gnt_i;
        end
    end

    // -------------------------------------------------------------------------
    // R channel. The outstanding count doubles as FIFO occupancy, so a
    // response with nothing outstanding is simply dropped.
    // -------------------------------------------------------------------------
    assign fifo_empty  = (cnt_reg == '0);
    assign pop         = out_rvalid_i & ~fifo_empty;
    assign head_idx    = fifo_view[rd_ptr_reg];
    assign mgr_rdata_o = out_rdata_i;
    assign mgr_err_o   = out_err_i;

    always_comb begin
        mgr_rvalid_o = '0;
        if (pop) begin
            mgr_rvalid_o[head_idx] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Lock and counter next state
    // -------------------------------------------------------------------------
    always_comb begin
        locked_next   = locked_reg;
        lock_idx_next = lock_idx_reg;
        if (handshake) begin
            locked_next = 1'b0;
        end else if (out_req_o) begin
            // Request presented but not accepted: pin this requester.
            locked_next   = 1'b1;
            lock_idx_next = winner;
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        case ({handshake, pop})
            2'b10:   cnt_next = cnt_reg + CntW'(1);
            2'b01:   cnt_next = cnt_reg - CntW'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            locked_reg   <= 1'b0;
            lock_idx_reg <= '0;
            cnt_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            locked_reg   <= locked_next;
            lock_idx_reg <= lock_idx_next;
            cnt_reg      <= cnt_next;
            if (handshake) begin
                wr_ptr_reg <= (wr_ptr_reg == LastPtr) ? '0 : wr_ptr_reg + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LastPtr) ? '0 : rd_ptr_reg + PtrW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Index FIFO storage, one register per slot. Issue is blocked when full,
    // so a push never overwrites a live entry.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < MaxTrans; gi++) begin : g_fifo
        idx_t entry_reg;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                entry_reg <= '0;
            end else if (handshake && (wr_ptr_reg == PtrW'(gi))) begin
                entry_reg <= winner;
            end
        end

        assign fifo_view[gi] = entry_reg;
    end

`ifndef SYNTHESIS
    // A response with no outstanding transaction is tolerated (ignored).
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     out_rvalid_i |-> !fifo_empty)
        else $warning("user_mgr_arbiter: rvalid with no outstanding transaction ignored");

    // A locked requester must keep its request up until granted.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     locked_reg |-> mgr_req_i[lock_idx_reg])
        else $error("user_mgr_arbiter: locked requester dropped req");
`endif

endmodule

// File: tb/tb_user_mgr_arbiter.sv
module tb_user_mgr_arbiter;

    localparam int N  = 2;
    localparam int MT = 2;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic [N-1:0]        mgr_req_i;
    logic [N-1:0]        mgr_gnt_o;
    logic [N-1:0][31:0]  mgr_addr_i;
    logic [N-1:0]        mgr_we_i;
    logic [N-1:0][3:0]   mgr_be_i;
    logic [N-1:0][31:0]  mgr_wdata_i;
    logic [N-1:0]        mgr_rvalid_o;
    logic [31:0]         mgr_rdata_o;
    logic                mgr_err_o;
    logic                out_req_o;
    logic [31:0]         out_addr_o;
    logic                out_we_o;
    logic [3:0]          out_be_o;
    logic [31:0]         out_wdata_o;
    logic                out_gnt_i;
    logic                out_rvalid_i;
    logic [31:0]         out_rdata_i;
    logic                out_err_i;

    always #5 clk_i = ~clk_i;

    user_mgr_arbiter #(.NumMgr(N), .MaxTrans(MT)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .mgr_req_i    (mgr_req_i),
        .mgr_gnt_o    (mgr_gnt_o),
        .mgr_addr_i   (mgr_addr_i),
        .mgr_we_i     (mgr_we_i),
        .mgr_be_i     (mgr_be_i),
        .mgr_wdata_i  (mgr_wdata_i),
        .mgr_rvalid_o (mgr_rvalid_o),
        .mgr_rdata_o  (mgr_rdata_o),
        .mgr_err_o    (mgr_err_o),
        .out_req_o    (out_req_o),
        .out_addr_o   (out_addr_o),
        .out_we_o     (out_we_o),
        .out_be_o     (out_be_o),
        .out_wdata_o  (out_wdata_o),
        .out_gnt_i    (out_gnt_i),
        .out_rvalid_i (out_rvalid_i),
        .out_rdata_i  (out_rdata_i),
        .out_err_i    (out_err_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                         input logic [31:0] rdata, input logic err);
        mgr_req_i    = req;
        out_gnt_i    = gnt;
        out_rvalid_i = rv;
        out_rdata_i  = rdata;
        out_err_i    = err;
    endtask

    // Compare all outputs against hand-written expectations; sel names the
    // requester whose A-channel payload must appear on out_*.
    task automatic row_check(input string tag, input logic exp_req, input logic [1:0] exp_gnt,
                             input logic [1:0] exp_rv, input int sel);
        chk({tag, ".out_req"},   32'(out_req_o),    32'(exp_req));
        chk({tag, ".gnt"},       32'(mgr_gnt_o),    32'(exp_gnt));
        chk({tag, ".rvalid"},    32'(mgr_rvalid_o), 32'(exp_rv));
        chk({tag, ".out_addr"},  out_addr_o,        mgr_addr_i[sel]);
        chk({tag, ".out_wdata"}, out_wdata_o,       mgr_wdata_i[sel]);
        chk({tag, ".rdata"},     mgr_rdata_o,       out_rdata_i);
        chk({tag, ".err"},       32'(mgr_err_o),    32'(out_err_i));
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    int m_q[$];
    bit m_locked;
    int m_lock_idx;
    int m_prio;

    function automatic int model_winner(input logic [N-1:0] req);
        if (m_locked) return m_lock_idx;
`ifdef USER_MGR_ARB_RR_EN
        for (int k = 0; k < N; k++)
            if (req[(m_prio + k) % N]) return (m_prio + k) % N;
`else
        for (int k = 0; k < N; k++)
            if (req[k]) return k;
`endif
        return 0;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_locked   = 1'b0;
        m_lock_idx = 0;
        m_prio     = 0;
    endfunction

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        exp_req;
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_rv;
        int          sel;
    } vec_t;

    vec_t tbl[18];
    logic [1:0] seq_gnt[4];
    logic [1:0] seq_rv[4];

    initial begin
        // Directed sequence: single access, stall/lock, saturation, ordering,
        // stray responses. Expectations hold for both arbitration modes.
        tbl[0]  = '{2'b01, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'b01, 2'b00, 0};
        tbl[1]  = '{2'b00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b00, 0};
        tbl[2]  = '{2'b00, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 2'b00, 2'b01, 0};
        tbl[3]  = '{2'b01, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 2'b00, 2'b00, 0};
        tbl[4]  = '{2'b11, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 2'b00, 2'b00, 0};
        tbl[5]  = '{2'b11, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 2'b00, 2'b00, 0};
        tbl[6]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'b01, 2'b00, 0};
        tbl[7]  = '{2'b10, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'b10, 2'b00, 1};
        tbl[8]  = '{2'b01, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b00, 0};
        tbl[9]  = '{2'b01, 1'b1, 1'b1, 32'h11111111, 1'b1, 1'b0, 2'b00, 2'b01, 0};
        tbl[10] = '{2'b01, 1'b1, 1'b1, 32'h22222222, 1'b0, 1'b1, 2'b01, 2'b10, 0};
        tbl[11] = '{2'b00, 1'b0, 1'b1, 32'h33333333, 1'b1, 1'b0, 2'b00, 2'b01, 0};
        tbl[12] = '{2'b00, 1'b0, 1'b1, 32'h44444444, 1'b0, 1'b0, 2'b00, 2'b00, 0};
        tbl[13] = '{2'b10, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'b10, 2'b00, 1};
        tbl[14] = '{2'b01, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'b01, 2'b00, 0};
        tbl[15] = '{2'b00, 1'b0, 1'b1, 32'h55555555, 1'b1, 1'b0, 2'b00, 2'b10, 0};
        tbl[16] = '{2'b00, 1'b0, 1'b1, 32'h66666666, 1'b0, 1'b0, 2'b00, 2'b01, 0};
        tbl[17] = '{2'b00, 1'b0, 1'b1, 32'h77777777, 1'b1, 1'b0, 2'b00, 2'b00, 0};

        // Both requesters requesting continuously with gnt=1, rvalid one
        // cycle after each grant.
`ifdef USER_MGR_ARB_RR_EN
        seq_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        seq_rv  = '{2'b00, 2'b01, 2'b10, 2'b01};
`else
        seq_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
        seq_rv  = '{2'b00, 2'b01, 2'b01, 2'b01};
`endif

        mgr_addr_i  = '{32'h3000_0010, 32'h2000_0000};
        mgr_wdata_i = '{32'hB1B1_B1B1, 32'hA0A0_A0A0};
        mgr_we_i    = 2'b10;
        mgr_be_i    = '{4'h3, 4'hF};
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);

        // ---------------- reset state ----------------
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        row_check("reset", 1'b0, 2'b00, 2'b00, 0);
        $display("reset: out_req=%b gnt=%b rvalid=%b addr=%h",
                 out_req_o, mgr_gnt_o, mgr_rvalid_o, out_addr_o);
        next_cycle();
        rst_ni = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].err);
            @(negedge clk_i);
            row_check($sformatf("row%0d", i), tbl[i].exp_req, tbl[i].exp_gnt,
                      tbl[i].exp_rv, tbl[i].sel);
            $display("row %0d: req=%b gnt_in=%b rvalid_in=%b -> out_req=%b gnt=%b rvalid=%b err=%b",
                     i, tbl[i].req, tbl[i].gnt, tbl[i].rv, out_req_o, mgr_gnt_o,
                     mgr_rvalid_o, mgr_err_o);
            next_cycle();
        end

        // ---------------- continuous dual request from reset ----------------
        rst_ni = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();
        rst_ni = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 1'b1, (c > 0), 32'h1000 + 32'(c), 1'b0);
            @(negedge clk_i);
            chk($sformatf("seq%0d.gnt", c), 32'(mgr_gnt_o), 32'(seq_gnt[c]));
            chk($sformatf("seq%0d.rvalid", c), 32'(mgr_rvalid_o), 32'(seq_rv[c]));
            $display("seq %0d: gnt=%b rvalid=%b", c, mgr_gnt_o, mgr_rvalid_o);
            next_cycle();
        end

        // ---------------- reset mid-operation (one transaction outstanding) --
        rst_ni = 1'b0;
        drive(2'b00, 1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0);
        @(negedge clk_i);
        chk("midrst.in_reset.rvalid", 32'(mgr_rvalid_o), 32'h0);
        next_cycle();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("midrst.after.rvalid", 32'(mgr_rvalid_o), 32'h0);
        $display("midrst: late rvalid -> rvalid=%b", mgr_rvalid_o);
        next_cycle();
        drive(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk_i);
        chk("midrst.reissue.gnt", 32'(mgr_gnt_o), 32'h2);
        next_cycle();
        drive(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
        @(negedge clk_i);
        chk("midrst.resp.rvalid", 32'(mgr_rvalid_o), 32'h2);
        next_cycle();

        // ---------------- randomized against the model ----------------
        rst_ni = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();
        rst_ni = 1'b1;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] req;
            logic         gnt, rv;
            int           w;
            bit           issue, e_req, do_pop, hs;
            logic [N-1:0] e_gnt, e_rv;

            req = N'($urandom);
            if (m_locked) req[m_lock_idx] = 1'b1;
            gnt = ($urandom_range(0, 3) != 0);
            rv  = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
            for (int k = 0; k < N; k++) begin
                mgr_addr_i[k]  = $urandom;
                mgr_wdata_i[k] = $urandom;
                mgr_we_i[k]    = 1'($urandom);
                mgr_be_i[k]    = 4'($urandom);
            end
            drive(req, gnt, rv, $urandom, 1'($urandom));

            w      = model_winner(req);
            issue  = (m_q.size() < MT);
            e_req  = issue && req[w];
            e_gnt  = (issue && gnt) ? (N'(1) << w) : '0;
            do_pop = rv && (m_q.size() > 0);
            e_rv   = do_pop ? (N'(1) << m_q[0]) : '0;

            @(negedge clk_i);
            chk($sformatf("rnd%0d.out_req", c), 32'(out_req_o), 32'(e_req));
            chk($sformatf("rnd%0d.gnt", c), 32'(mgr_gnt_o), 32'(e_gnt));
            chk($sformatf("rnd%0d.rvalid", c), 32'(mgr_rvalid_o), 32'(e_rv));
            chk($sformatf("rnd%0d.out_addr", c), out_addr_o, mgr_addr_i[w]);
            chk($sformatf("rnd%0d.out_we", c), 32'(out_we_o), 32'(mgr_we_i[w]));
            chk($sformatf("rnd%0d.out_be", c), 32'(out_be_o), 32'(mgr_be_i[w]));
            chk($sformatf("rnd%0d.out_wdata", c), out_wdata_o, mgr_wdata_i[w]);
            chk($sformatf("rnd%0d.rdata", c), mgr_rdata_o, out_rdata_i);
            chk($sformatf("rnd%0d.err", c), 32'(mgr_err_o), 32'(out_err_i));

            hs = e_req && gnt;
            if (hs || do_pop)
                $display("rnd %0d: %s%s", c,
                         hs ? $sformatf("grant mgr%0d addr=%h ", w, mgr_addr_i[w]) : "",
                         do_pop ? $sformatf("resp mgr%0d", m_q[0]) : "");

            if (do_pop) void'(m_q.pop_front());
            if (hs) begin
                m_q.push_back(w);
                m_locked = 1'b0;
                m_prio   = (w + 1) % N;
            end else if (e_req) begin
                m_locked   = 1'b1;
                m_lock_idx = w;
            end
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
